pipeline_buf: RTL and testbench
===============================

Name: pipeline_buf

Overview:
- Elastic, parametrised successor to the single-entry pipeline register between CPU pipeline stages (e.g. IF->ID, ID->EX).
- Holds up to DEPTH in-flight entries in a circular buffer.
- allow_in depends only on occupancy (plus flush), so the combinational allow_out -> allow_in chain between stages is cut.
- Keeps the existing stall/flush/valid-allow handshake semantics, so it drops into the same slots.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 2, number of entries; legal values >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  holds this stage's output: suppresses valid_out and pops.
- flush  input  1  discards all buffered entries and the incoming entry this cycle.
- valid_in  input  1  upstream offers an entry.
- allow_in  output  1  this stage accepts an entry this cycle.
- allow_out  input  1  downstream accepts an entry this cycle.
- valid_out  output  1  this stage offers its head entry downstream.
- in  input  WIDTH  upstream payload.
- out  output  WIDTH  head-entry payload.
- valid  output  1  buffer non-empty, ungated by stall.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x WIDTH array; head (read) and tail (write) pointers wrap modulo DEPTH (DEPTH need not be a power of two); count register.
- Storage array is not reset. Pointers and count are reset.
- Reset values: count=0, head=tail=0, valid=0, valid_out=0, allow_in=1, out=0.
- Reset mid-operation: all entries are lost in one cycle, with the same end state as power-on reset.
- allow_in = (count != DEPTH) | flush.
  - No combinational dependence on allow_out or stall.
- valid = (count != 0).
- valid_out = valid & ~stall.
  - valid_out is not gated by flush.
  - A handshake completing in a flush cycle counts as delivered downstream.
- out = mem[head] when count != 0, else all zeros.
- push = valid_in & allow_in & ~flush: write in to mem[tail], tail advances.
- pop = valid_out & allow_out: head advances.
- Count update when not flushing: push only +1; pop only -1; both, or neither, unchanged.
- Flush (when not in reset): count<=0, head<=0, tail<=0. Any simultaneous push or pop is ignored internally. Flush has priority over push and pop.
- Latency: one cycle minimum, with no bypass.
  - A push into an empty buffer appears on valid_out/out the next cycle.
  - When empty, push and pop never coincide.
- Throughput: one entry per cycle sustained while count is between 1 and DEPTH-1.
- When full (count=DEPTH), allow_in=0 even if a pop occurs in the same cycle. There is no full-bypass; DEPTH >= 2 still sustains full rate.
- Stall: valid_out=0 and no pops. Pushes continue until full. Contents and order are preserved across a stall.
- Order: strict FIFO. Entries leave in acceptance order, including across pointer wrap-around.
- Upstream protocol: while valid_in=1 and allow_in=0, upstream holds in stable. The block does not check this.

Test Plan (WIDTH=8, DEPTH=4 unless noted):
- Reset: assert reset 2 cycles with valid_in=1 -> count=0, valid_out=0, allow_in=1, out=8'h00; the first push after reset of 8'hA5 -> next cycle valid_out=1, out=8'hA5, count=1.
- Fill then back-pressure: allow_out=0, push 8'h01..8'h04 -> count=4, allow_in=0; 8'h05 is offered and held until allow_out=1 -> pops 01,02,03,04,05 in order; allow_in returns to 1 the cycle after the first pop.
- Streaming with wrap: allow_out=1, push 8'h00..8'h0F every cycle -> outputs in order with 1-cycle latency, count stays at 1, no bubbles, head/tail wrap 4 times.
- Stall: with 8'h10,8'h11 buffered, stall=1 for 3 cycles while pushing 8'h12,8'h13 -> valid_out=0, count reaches 4, allow_in=0; stall released -> 10,11,12,13 delivered in order.
- Flush: with count=3 and valid_in=1, in=8'hEE, allow_out=1, pulse flush -> valid_out=1 that cycle (head delivered); next cycle count=0, valid_out=0; 8'hEE is never output.
- DEPTH=3 (non power of two): stream 8'h20..8'h2A with random allow_out and stall -> output order exact, count never exceeds 3, pointers wrap correctly.

Source files
------------

// File: rtl/pipeline_buf_if.sv
// ---------------------------------------------------------------------------
// pipeline_buf_if
//   Handshake bundle for one elastic pipeline stage buffer.
//
//   Upstream side   : valid_in, in        -> buffer ; allow_in  -> upstream
//   Downstream side : valid_out, out      -> downstream ; allow_out -> buffer
//   Stage control   : stall, flush        -> buffer
//   Status          : valid, count        -> observer
//
//   modport slave  : the buffer's view (drives allow_in/valid_out/out/status)
//   modport master : the surrounding pipeline's view (drives everything else)
// ---------------------------------------------------------------------------
interface pipeline_buf_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic             stall;
   logic             flush;
   logic             valid_in;
   logic             allow_in;
   logic [WIDTH-1:0] in;
   logic             valid_out;
   logic             allow_out;
   logic [WIDTH-1:0] out;
   logic             valid;
   logic [CW-1:0]    count;

   modport slave (
      input  stall, flush, valid_in, in, allow_out,
      output allow_in, valid_out, out, valid, count
   );

   modport master (
      output stall, flush, valid_in, in, allow_out,
      input  allow_in, valid_out, out, valid, count
   );
endinterface

// File: rtl/pipeline_buf.sv
// ---------------------------------------------------------------------------
// pipeline_buf
//   Elastic pipeline register placed between two CPU pipeline stages.
//   Holds up to DEPTH entries in a circular buffer. allow_in is derived only
//   from occupancy (and flush), so the allow_out -> allow_in combinational
//   path that a single-entry stage register creates is broken here.
//
//   Ports
//     clk   : clock
//     reset : synchronous, active-high reset (pointers and count only)
//     bus   : pipeline_buf_if.slave
//               stall     in  : hold output (no valid_out, no pops)
//               flush     in  : drop all entries and the incoming one
//               valid_in  in  : upstream offers an entry
//               allow_in  out : stage accepts an entry this cycle
//               in        in  : upstream payload
//               valid_out out : head entry offered downstream
//               allow_out in  : downstream accepts this cycle
//               out       out : head payload (zero when empty)
//               valid     out : buffer non-empty, ignores stall
//               count     out : occupancy 0..DEPTH
//
//   Parameters
//     WIDTH : payload width
//     DEPTH : entry count, must be >= 2; need not be a power of two
//     CW    : occupancy width, derived
// ---------------------------------------------------------------------------
module pipeline_buf #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   pipeline_buf_if.slave  bus
);

   // Pointer width; DEPTH >= 2 keeps this at least one bit.
   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Storage is deliberately not reset: only the bookkeeping is.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic allow_in;
   logic valid_out;
   logic push;
   logic pop;

   // Explicit wrap so non power-of-two depths index only legal slots.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A full buffer refuses input even if the head pops this cycle; that
   // keeps allow_in free of any allow_out/stall dependence. Flush opens
   // the input, but the offered entry is dropped (push is gated below).
   assign allow_in  = ~full | bus.flush;

   // flush does not gate valid_out: a head handshake in a flush cycle is
   // treated as delivered, the buffer is simply emptied afterwards.
   assign valid_out = ~empty & ~bus.stall;

   assign push = bus.valid_in & allow_in & ~bus.flush;
   assign pop  = valid_out & bus.allow_out;

   assign bus.allow_in  = allow_in;
   assign bus.valid_out = valid_out;
   assign bus.valid     = ~empty;
   assign bus.count     = count;
   assign bus.out       = empty ? '0 : mem[head];

   // Bookkeeping: reset, then flush, then push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage; entry written at tail only on an accepted push.
   always_ff @(posedge clk) begin
      if (push && !reset) mem[tail] <= bus.in;
   end

   // Structural sanity checks on the bookkeeping.
   a_count_range : assert property (@(posedge clk) disable iff (reset)
      count <= FULL_CNT);
   a_no_push_full : assert property (@(posedge clk) disable iff (reset)
      !(push && full));
   a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
      !(pop && empty));

endmodule

// File: tb/tb_pipeline_buf.sv
// Bench for pipeline_buf: a DEPTH=4 and a DEPTH=3 instance (WIDTH=8) share
// one stimulus stream; each is checked every cycle against its own queue
// model. A directed table pins the DEPTH=4 outputs to hand-derived values.
module tb_pipeline_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       st, fl, vi, ao;
   logic [7:0] din;

   always #5 clk = ~clk;

   pipeline_buf_if #(.WIDTH(8), .DEPTH(4)) b4 ();
   pipeline_buf_if #(.WIDTH(8), .DEPTH(3)) b3 ();

   assign b4.stall = st;  assign b4.flush = fl;  assign b4.valid_in = vi;
   assign b4.in = din;    assign b4.allow_out = ao;
   assign b3.stall = st;  assign b3.flush = fl;  assign b3.valid_in = vi;
   assign b3.in = din;    assign b3.allow_out = ao;

   pipeline_buf #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .reset(rst), .bus(b4));
   pipeline_buf #(.WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .reset(rst), .bus(b3));

   typedef struct {
      bit       rst, st, fl, vi;
      bit [7:0] din;
      bit       ao;
      bit       e_vo, e_ai;
      bit [7:0] e_out;
      int       e_cnt;
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [7:0] q4[$];
   logic [7:0] q3[$];
   logic [7:0] rx4[$];
   logic [7:0] rx3[$];

   function automatic vec_t mk(bit r, bit s, bit f, bit v, bit [7:0] d, bit a,
                               bit evo, bit eai, bit [7:0] eo, int ec);
      vec_t t;
      t.rst = r; t.st = s; t.fl = f; t.vi = v; t.din = d; t.ao = a;
      t.e_vo = evo; t.e_ai = eai; t.e_out = eo; t.e_cnt = ec;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // One clock: inputs already driven; compare just before the edge, then
   // advance both models with the rules of the stage.
   task automatic run_cycle(input bit use_tbl, input vec_t v);
      bit         m4_vo, m4_ai, m3_vo, m3_ai;
      logic [7:0] m4_out, m3_out;
      int         m4_cnt, m3_cnt;
      @(negedge clk);
      m4_cnt = q4.size();  m3_cnt = q3.size();
      m4_vo  = (m4_cnt != 0) && !st;
      m3_vo  = (m3_cnt != 0) && !st;
      m4_ai  = (m4_cnt != 4) || fl;
      m3_ai  = (m3_cnt != 3) || fl;
      m4_out = (m4_cnt != 0) ? q4[0] : 8'h00;
      m3_out = (m3_cnt != 0) ? q3[0] : 8'h00;
      if (use_tbl) begin
         chk("tbl_valid_out", 32'(b4.valid_out), 32'(v.e_vo));
         chk("tbl_allow_in",  32'(b4.allow_in),  32'(v.e_ai));
         chk("tbl_out",       32'(b4.out),       32'(v.e_out));
         chk("tbl_count",     32'(b4.count),     32'(v.e_cnt));
      end else begin
         chk("d4_valid_out", 32'(b4.valid_out), 32'(m4_vo));
         chk("d4_allow_in",  32'(b4.allow_in),  32'(m4_ai));
         chk("d4_out",       32'(b4.out),       32'(m4_out));
         chk("d4_count",     32'(b4.count),     32'(m4_cnt));
      end
      chk("d4_valid", 32'(b4.valid), 32'(m4_cnt != 0));
      chk("d3_valid_out", 32'(b3.valid_out), 32'(m3_vo));
      chk("d3_allow_in",  32'(b3.allow_in),  32'(m3_ai));
      chk("d3_out",       32'(b3.out),       32'(m3_out));
      chk("d3_count",     32'(b3.count),     32'(m3_cnt));
      chk("d3_valid",     32'(b3.valid),     32'(m3_cnt != 0));
      if (b4.valid_out === 1'b1 && ao) rx4.push_back(b4.out);
      if (b3.valid_out === 1'b1 && ao) rx3.push_back(b3.out);
      @(posedge clk);
      if (rst || fl) begin
         q4.delete();
         q3.delete();
      end else begin
         if (m4_vo && ao) void'(q4.pop_front());
         if (m3_vo && ao) void'(q3.pop_front());
         if (vi && m4_ai) q4.push_back(din);
         if (vi && m3_ai) q3.push_back(din);
      end
      #1;
   endtask

   task automatic drive(input bit r, s, f, v, input logic [7:0] d, input bit a);
      rst = r; st = s; fl = f; vi = v; din = d; ao = a;
   endtask

   vec_t tbl[$];
   vec_t dummy;

   initial begin
      dummy = mk(0,0,0,0,8'h00,0,0,0,8'h00,0);
      //              rst st fl vi din   ao  vo ai out   cnt
      tbl.push_back(mk(1, 0, 0, 1, 8'h33, 0,  0, 1, 8'h00, 0)); // reset, 2nd cycle
      tbl.push_back(mk(0, 0, 0, 1, 8'hA5, 0,  0, 1, 8'h00, 0)); // first push
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  1, 1, 8'hA5, 1)); // 1-cycle latency
      tbl.push_back(mk(0, 0, 0, 1, 8'h01, 0,  0, 1, 8'h00, 0)); // fill 01..04
      tbl.push_back(mk(0, 0, 0, 1, 8'h02, 0,  1, 1, 8'h01, 1));
      tbl.push_back(mk(0, 0, 0, 1, 8'h03, 0,  1, 1, 8'h01, 2));
      tbl.push_back(mk(0, 0, 0, 1, 8'h04, 0,  1, 1, 8'h01, 3));
      tbl.push_back(mk(0, 0, 0, 1, 8'h05, 0,  1, 0, 8'h01, 4)); // full, 05 held
      tbl.push_back(mk(0, 0, 0, 1, 8'h05, 1,  1, 0, 8'h01, 4)); // pop, still blocked
      tbl.push_back(mk(0, 0, 0, 1, 8'h05, 1,  1, 1, 8'h02, 3)); // 05 accepted
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  1, 1, 8'h03, 3));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  1, 1, 8'h04, 2));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  1, 1, 8'h05, 1));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0,  0, 1, 8'h00, 0)); // drained
      tbl.push_back(mk(0, 0, 0, 1, 8'h30, 0,  0, 1, 8'h00, 0)); // build count=3
      tbl.push_back(mk(0, 0, 0, 1, 8'h31, 0,  1, 1, 8'h30, 1));
      tbl.push_back(mk(0, 0, 0, 1, 8'h32, 0,  1, 1, 8'h30, 2));
      tbl.push_back(mk(0, 0, 1, 1, 8'hEE, 1,  1, 1, 8'h30, 3)); // flush, head delivered
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0)); // EE never seen
      tbl.push_back(mk(0, 1, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0)); // stall on empty
      tbl.push_back(mk(0, 0, 0, 1, 8'h40, 0,  0, 1, 8'h00, 0)); // fill to full
      tbl.push_back(mk(0, 0, 0, 1, 8'h41, 0,  1, 1, 8'h40, 1));
      tbl.push_back(mk(0, 0, 0, 1, 8'h42, 0,  1, 1, 8'h40, 2));
      tbl.push_back(mk(0, 0, 0, 1, 8'h43, 0,  1, 1, 8'h40, 3));
      tbl.push_back(mk(0, 0, 1, 1, 8'h44, 0,  1, 1, 8'h40, 4)); // flush opens allow_in
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0,  0, 1, 8'h00, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h50, 0,  0, 1, 8'h00, 0)); // reset mid-run
      tbl.push_back(mk(0, 0, 0, 1, 8'h51, 0,  1, 1, 8'h50, 1));
      tbl.push_back(mk(1, 0, 0, 1, 8'h52, 1,  1, 1, 8'h50, 2));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0));

      // First reset cycle: state undefined before the edge, so not compared.
      drive(1, 0, 0, 1, 8'h33, 0);
      @(posedge clk); #1;
      q4.delete(); q3.delete();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].vi, tbl[i].din, tbl[i].ao);
         run_cycle(1'b1, tbl[i]);
      end

      // Streaming 00..0F, one per cycle, through pointer wrap.
      rx4.delete();
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 1, 8'(i), 1);
         run_cycle(1'b0, dummy);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 8'h00, 1);
         run_cycle(1'b0, dummy);
      end
      chk("stream_len", 32'(rx4.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx4.size(); i++)
         chk("stream_order", 32'(rx4[i]), 32'(i));

      // Stall with 10,11 buffered while 12,13 are pushed.
      rx4.delete();
      drive(0, 0, 0, 1, 8'h10, 0); run_cycle(1'b0, dummy);
      drive(0, 0, 0, 1, 8'h11, 0); run_cycle(1'b0, dummy);
      drive(0, 1, 0, 1, 8'h12, 1); run_cycle(1'b0, dummy);
      drive(0, 1, 0, 1, 8'h13, 1); run_cycle(1'b0, dummy);
      drive(0, 1, 0, 0, 8'h00, 1); run_cycle(1'b0, dummy);
      chk("stall_count", 32'(b4.count), 32'd4);
      chk("stall_allow_in", 32'(b4.allow_in), 32'd0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0, 8'h00, 1);
         run_cycle(1'b0, dummy);
      end
      chk("stall_len", 32'(rx4.size()), 32'd4);
      for (int i = 0; i < 4 && i < rx4.size(); i++)
         chk("stall_order", 32'(rx4[i]), 32'(8'h10 + i));

      // DEPTH=3: stream 20..2A under random allow_out and stall.
      drive(1, 0, 0, 0, 8'h00, 0); run_cycle(1'b0, dummy);
      rx3.delete();
      begin
         int k = 0;
         for (int cyc = 0; cyc < 300 && rx3.size() < 11; cyc++) begin
            bit acc;
            drive(0, ($urandom_range(0, 3) == 0), 0, (k < 11), 8'(8'h20 + k),
                  1'($urandom_range(0, 1)));
            acc = vi && (q3.size() < 3);
            run_cycle(1'b0, dummy);
            if (acc) k++;
         end
      end
      chk("d3_len", 32'(rx3.size()), 32'd11);
      for (int i = 0; i < 11 && i < rx3.size(); i++)
         chk("d3_order", 32'(rx3[i]), 32'(8'h20 + i));

      // Fully random traffic including flush and reset on both depths.
      for (int cyc = 0; cyc < 600; cyc++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
               8'($urandom), ($urandom_range(0, 2) != 0));
         run_cycle(1'b0, dummy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
